// File: rtl/roi_io_harness.sv
// roi_io_harness
//
// Serial I/O wrapper for a timing ROI. A single-pin serial stream on `di`
// is shifted into a DIN_N-bit register and presented to the ROI as `din`
// when `stb` pulses. On the same strobe the ROI's `dout` word is captured
// and shifted out MSB first on `do_ser`. With no strobe the two shift
// registers form one continuous chain, so `do_ser` replays `di` after
// DIN_N+DOUT_N cycles.
//
// Parameters:
//   DIN_N        ROI input width  (>= 1)
//   DOUT_N       ROI output width (>= 1)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset, overrides everything
//   stb          frame strobe: load din, capture dout
//   di           serial input, MSB first
//   do_ser       serial output, MSB first (the package "do" pin)
//   din          parallel word to the ROI, held between strobes
//   dout         parallel word from the ROI, sampled only on strobe
//   din_valid    one-cycle pulse following a din update
//   short_frame  sticky flag: a strobe arrived with fewer than DIN_N bits
//                shifted in since the previous strobe or reset
module roi_io_harness #(
    parameter int DIN_N  = 8,
    parameter int DOUT_N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stb,
    input  logic              di,
    output logic              do_ser,
    output logic [DIN_N-1:0]  din,
    input  logic [DOUT_N-1:0] dout,
    output logic              din_valid,
    output logic              short_frame
);

    localparam int CNT_W = $clog2(DIN_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIN_N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DIN_N-1:0]  din_shr;
    logic [DOUT_N-1:0] dout_shr;
    logic [CNT_W-1:0]  bit_cnt;

    logic [DIN_N-1:0]  din_shr_next;
    logic [DOUT_N-1:0] dout_shr_next;

    // Saturating bit counter: once a full frame is in, further bits don't
    // matter for short-frame detection, so the count just parks at DIN_N.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    // Shift paths; the 1-bit cases degenerate to a plain register load.
    generate
        if (DIN_N == 1) begin : g_din_1
            assign din_shr_next = di;
        end else begin : g_din_n
            assign din_shr_next = {din_shr[DIN_N-2:0], di};
        end

        if (DOUT_N == 1) begin : g_dout_1
            assign dout_shr_next = din_shr[DIN_N-1];
        end else begin : g_dout_n
            assign dout_shr_next = {dout_shr[DOUT_N-2:0], din_shr[DIN_N-1]};
        end
    endgenerate

    // ---- register stage: shift chain, frame load and capture ----
    always_ff @(posedge clk) begin
        if (rst) begin
            din_shr     <= '0;
            dout_shr    <= '0;
            din         <= '0;
            bit_cnt     <= '0;
            din_valid   <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            // The input chain keeps shifting on a strobe; that bit belongs
            // to the next frame, hence the counter restarts at one.
            din_shr <= din_shr_next;
            if (stb) begin
                din       <= din_shr;
                dout_shr  <= dout;
                bit_cnt   <= CNT_ONE;
                din_valid <= 1'b1;
                if (bit_cnt < CNT_MAX) begin
                    short_frame <= 1'b1;
                end
            end else begin
                dout_shr  <= dout_shr_next;
                bit_cnt   <= sat_inc(bit_cnt);
                din_valid <= 1'b0;
            end
        end
    end

    // Serial output straight from the register: no input-to-pin path.
    assign do_ser = dout_shr[DOUT_N-1];

endmodule

// File: tb/tb_roi_io_harness.sv
module tb_roi_io_harness;

    localparam int DIN_N  = 8;
    localparam int DOUT_N = 8;

    logic              clk;
    logic              rst;
    logic              stb;
    logic              di;
    logic              do_ser;
    logic [DIN_N-1:0]  din;
    logic [DOUT_N-1:0] dout;
    logic              din_valid;
    logic              short_frame;

    int n_checks = 0;
    int n_fail   = 0;

    roi_io_harness #(.DIN_N(DIN_N), .DOUT_N(DOUT_N)) dut (
        .clk         (clk),
        .rst         (rst),
        .stb         (stb),
        .di          (di),
        .do_ser      (do_ser),
        .din         (din),
        .dout        (dout),
        .din_valid   (din_valid),
        .short_frame (short_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the serial stream as a queue of the last DIN_N
    // bits received (oldest first) and a queue of the bits still to appear
    // on the output pin (front = current pin value).
    logic di_hist[$];
    logic out_q[$];
    logic [DIN_N-1:0] exp_din;
    logic exp_valid;
    logic exp_short;
    int   frame_bits;

    task automatic model_reset();
        di_hist.delete();
        out_q.delete();
        for (int i = 0; i < DIN_N; i++) di_hist.push_back(1'b0);
        for (int i = 0; i < DOUT_N; i++) out_q.push_back(1'b0);
        exp_din    = '0;
        exp_valid  = 1'b0;
        exp_short  = 1'b0;
        frame_bits = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then
    // settle 1 time unit past the edge so the caller can compare.
    task automatic step(input logic s, input logic d, input logic r,
                        input logic [DOUT_N-1:0] dw);
        logic tmp;
        stb  = s;
        di   = d;
        rst  = r;
        dout = dw;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (s) begin
                for (int i = 0; i < DIN_N; i++) exp_din[DIN_N-1-i] = di_hist[i];
                if (frame_bits < DIN_N) exp_short = 1'b1;
                exp_valid = 1'b1;
                out_q.delete();
                for (int i = DOUT_N - 1; i >= 0; i--) out_q.push_back(dw[i]);
                frame_bits = 1;
            end else begin
                tmp = out_q.pop_front();
                out_q.push_back(di_hist[0]);
                exp_valid = 1'b0;
                frame_bits = (frame_bits + 1 > DIN_N) ? DIN_N : frame_bits + 1;
            end
            tmp = di_hist.pop_front();
            di_hist.push_back(d);
        end
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        n_checks++;
        if (do_ser !== 1'b0) begin n_fail++; $display("FAIL reset_do: got %b want 0", do_ser); end
        n_checks++;
        if (din !== 8'h00) begin n_fail++; $display("FAIL reset_din: got %h want 00", din); end
        n_checks++;
        if (din_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", din_valid); end
        n_checks++;
        if (short_frame !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %b want 0", short_frame); end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (din !== 8'h00 || din_valid !== 1'b0 || short_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: din=%h valid=%b short=%b want 00/0/0", din, din_valid, short_frame);
        end
    endtask

    task automatic test_load();
        logic [7:0] w;
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) step(1'b0, w[i], 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (din !== 8'hA5) begin n_fail++; $display("FAIL load_din: got %h want a5", din); end
        n_checks++;
        if (din_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid_hi: got %b want 1", din_valid); end
        n_checks++;
        if (short_frame !== 1'b0) begin n_fail++; $display("FAIL load_short: got %b want 0", short_frame); end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (din_valid !== 1'b0) begin n_fail++; $display("FAIL load_valid_lo: got %b want 0", din_valid); end
        n_checks++;
        if (din !== 8'hA5) begin n_fail++; $display("FAIL load_din_hold: got %h want a5", din); end
    endtask

    task automatic test_capture();
        logic [7:0] pat;
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) step(1'b0, rbit(), 1'b0, 8'h00);
        step(1'b1, rbit(), 1'b0, pat);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) step(1'b0, rbit(), 1'b0, 8'hFF);
            n_checks++;
            if (do_ser !== pat[7-j]) begin
                n_fail++;
                $display("FAIL capture_bit%0d: got %b want %b", j, do_ser, pat[7-j]);
            end
        end
    endtask

    task automatic test_short_frame();
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, rbit(), 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (short_frame !== 1'b1) begin n_fail++; $display("FAIL short_set: got %b want 1", short_frame); end
        n_checks++;
        if (din !== exp_din || din_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL short_load: din=%h valid=%b want %h/1", din, din_valid, exp_din);
        end
        // A later full frame must not clear the sticky flag.
        for (int i = 0; i < 8; i++) step(1'b0, rbit(), 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (short_frame !== 1'b1) begin n_fail++; $display("FAIL short_sticky: got %b want 1", short_frame); end
        n_checks++;
        if (din !== exp_din) begin n_fail++; $display("FAIL short_full_din: got %h want %h", din, exp_din); end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (short_frame !== 1'b0) begin n_fail++; $display("FAIL short_clear: got %b want 0", short_frame); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) step(1'b0, rbit(), 1'b0, 8'h00);
        step(1'b1, rbit(), 1'b0, 8'h81);
        n_checks++;
        if (short_frame !== 1'b0 || din !== exp_din) begin
            n_fail++;
            $display("FAIL b2b_first: short=%b din=%h want 0/%h", short_frame, din, exp_din);
        end
        step(1'b1, rbit(), 1'b0, 8'h42);
        n_checks++;
        if (short_frame !== 1'b1) begin n_fail++; $display("FAIL b2b_short: got %b want 1", short_frame); end
        n_checks++;
        if (din !== exp_din || din_valid !== 1'b1 || do_ser !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: din=%h valid=%b do=%b want %h/1/0", din, din_valid, do_ser, exp_din);
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_passthrough();
        logic sent[64];
        int bad;
        bad = 0;
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 64; i++) begin
            sent[i] = rbit();
            step(1'b0, sent[i], 1'b0, 8'h00);
            // The bit sampled at edge i reaches the pin after edge i+15,
            // i.e. it occupies the 16th cycle after the one it was driven in.
            if (i >= 15) begin
                n_checks++;
                if (do_ser !== sent[i-15]) begin
                    n_fail++;
                    bad++;
                    if (bad < 5) $display("FAIL pass_bit%0d: got %b want %b", i - 15, do_ser, sent[i-15]);
                end
            end else begin
                n_checks++;
                if (do_ser !== 1'b0) begin n_fail++; $display("FAIL pass_fill%0d: got %b want 0", i, do_ser); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        n_checks++;
        if (din !== 8'h00 || din_valid !== 1'b0 || short_frame !== 1'b0 || do_ser !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: din=%h valid=%b short=%b do=%b want 00/0/0/0",
                     din, din_valid, short_frame, do_ser);
        end
        w = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, w[i], 1'b0, 8'h00);
            n_checks++;
            if (din_valid !== 1'b0 || din !== 8'h00) begin
                n_fail++;
                $display("FAIL midrst_idle%0d: valid=%b din=%h want 0/00", i, din_valid, din);
            end
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (din !== 8'h5A || din_valid !== 1'b1 || short_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_reload: din=%h valid=%b short=%b want 5a/1/0", din, din_valid, short_frame);
        end
    endtask

    task automatic test_random();
        int bad;
        logic s, r;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 79) == 0);
            step(s, rbit(), r, 8'($urandom));
            n_checks++;
            if (do_ser !== out_q[0] || din !== exp_din || din_valid !== exp_valid || short_frame !== exp_short) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL random_cyc%0d: do=%b din=%h valid=%b short=%b want %b/%h/%b/%b",
                             i, do_ser, din, din_valid, short_frame, out_q[0], exp_din, exp_valid, exp_short);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        stb  = 1'b0;
        di   = 1'b0;
        dout = '0;
        model_reset();
        test_reset();
        test_load();
        test_capture();
        test_short_frame();
        test_back_to_back();
        test_passthrough();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
